// File: rtl/led_regs_pkg.sv
// Shared constants, types and helpers for the LED shadow register file.
package led_regs_pkg;

    localparam int unsigned Mode1Idx = 0;
    localparam int unsigned Mode2Idx = 1;
    localparam int unsigned OchBit   = 3;
    localparam int unsigned FullBit  = 4;
    localparam int unsigned FieldW   = 13;

    localparam int unsigned ByteOnL  = 0;
    localparam int unsigned ByteOnH  = 1;
    localparam int unsigned ByteOffL = 2;
    localparam int unsigned ByteOffH = 3;

    localparam logic [7:0] LoByteRst  = 8'h00;
    localparam logic [7:0] OnHRst     = 8'h00;
    localparam logic [7:0] OffHRst    = 8'h10;
    localparam logic [FieldW-1:0] OnFieldRst  = 13'h0000;
    localparam logic [FieldW-1:0] OffFieldRst = 13'h1000;

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } scan_state_e;

    // hi carries only the bits that matter: [4] full flag, [3:0] count MSBs.
    function automatic logic [FieldW-1:0] pack_field(input logic [4:0] hi, input logic [7:0] lo);
        return {hi[FullBit], hi[3:0], lo};
    endfunction

endpackage

// File: rtl/led_commit_scan.sv
// Sequential commit-on-STOP scanner: walks every channel index once per start pulse.
module led_commit_scan
    import led_regs_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 16,
    localparam int unsigned IdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            scan_valid_o,
    output logic [IdxW-1:0] scan_idx_o,
    output logic            scan_busy_o
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHANNELS - 1);

    scan_state_e     state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        // A new start always wins, including mid-scan restarts.
        if (start_i) begin
            state_d = StScan;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    idx_d = '0;
                end
                StScan: begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign scan_valid_o = (state_q == StScan);
    assign scan_idx_o   = idx_q;
    assign scan_busy_o  = (state_q == StScan);

endmodule

// File: rtl/led_shadow_regs.sv
// Staged/active LED register file: bytes written over I2C are staged, then committed
// atomically per channel either on write-ACK (OCH=1) or by a scan after STOP (OCH=0).
module led_shadow_regs
    import led_regs_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 16,
    parameter logic [7:0]  BASE_ADDR    = 8'h06,
    parameter logic [7:0]  ALL_ADDR     = 8'hFA,
    parameter logic [7:0]  MODE1_RST    = 8'h11,
    parameter logic [7:0]  MODE2_RST    = 8'h04
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [7:0]                     wr_addr_i,
    input  logic [7:0]                     wr_data_i,
    input  logic [7:0]                     rd_addr_i,
    output logic [7:0]                     rd_data_o,
    input  logic                           i2c_stop_i,
    output logic [7:0]                     mode1_o,
    output logic [7:0]                     mode2_o,
    output logic [FieldW*NUM_CHANNELS-1:0] led_on_o,
    output logic [FieldW*NUM_CHANNELS-1:0] led_off_o,
    output logic [NUM_CHANNELS-1:0]        commit_o,
    output logic                           scan_busy_o
);

    localparam int NumGen = int'(BASE_ADDR);
    localparam int NumCh  = int'(NUM_CHANNELS);
    localparam int unsigned IdxW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [8:0] ChSpan = 9'(4 * NUM_CHANNELS);

    logic [7:0]        gen_q   [NumGen];
    logic [7:0]        gen_d   [NumGen];
    logic [7:0]        stage_q [NumCh][4];
    logic [7:0]        stage_d [NumCh][4];
    logic [3:0]        dirty_q [NumCh];
    logic [3:0]        dirty_d [NumCh];
    logic [FieldW-1:0] on_q    [NumCh];
    logic [FieldW-1:0] on_d    [NumCh];
    logic [FieldW-1:0] off_q   [NumCh];
    logic [FieldW-1:0] off_d   [NumCh];

    logic [NUM_CHANNELS-1:0] commit_now, commit_q;
    logic [7:0]              rd_next, rd_data_q;
    logic                    och, scan_start, scan_valid;
    logic [IdxW-1:0]         scan_idx;

    logic       wr_is_gen, wr_is_ch, wr_is_all;
    logic [8:0] wr_off, wr_all_off;
    logic       rd_is_gen, rd_is_ch;
    logic [8:0] rd_off;

    assign och        = gen_q[Mode2Idx][OchBit];
    assign scan_start = i2c_stop_i && !och;

    led_commit_scan #(
        .NUM_CHANNELS (NUM_CHANNELS)
    ) u_scan (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (scan_start),
        .scan_valid_o (scan_valid),
        .scan_idx_o   (scan_idx),
        .scan_busy_o  (scan_busy_o)
    );

    // Address decode done in 9 bits so BASE/ALL windows near 8'hFF cannot wrap.
    assign wr_off     = {1'b0, wr_addr_i} - {1'b0, BASE_ADDR};
    assign wr_all_off = {1'b0, wr_addr_i} - {1'b0, ALL_ADDR};
    assign wr_is_gen  = wr_addr_i < BASE_ADDR;
    assign wr_is_ch   = !wr_is_gen && (wr_off < ChSpan);
    assign wr_is_all  = (wr_addr_i >= ALL_ADDR) && (wr_all_off < 9'd4);

    assign rd_off    = {1'b0, rd_addr_i} - {1'b0, BASE_ADDR};
    assign rd_is_gen = rd_addr_i < BASE_ADDR;
    assign rd_is_ch  = !rd_is_gen && (rd_off < ChSpan);

    always_comb begin
        gen_d   = gen_q;
        stage_d = stage_q;
        dirty_d = dirty_q;
        on_d    = on_q;
        off_d   = off_q;

        // Commits sample the pre-write staged bytes; a same-cycle write re-dirties after.
        for (int c = 0; c < NumCh; c++) begin
            commit_now[c] = (och && !wr_en_i && (&dirty_q[c])) ||
                            (scan_valid && (scan_idx == IdxW'(c)) && (|dirty_q[c]));
            if (commit_now[c]) begin
                on_d[c]    = pack_field(stage_q[c][ByteOnH][4:0], stage_q[c][ByteOnL]);
                off_d[c]   = pack_field(stage_q[c][ByteOffH][4:0], stage_q[c][ByteOffL]);
                dirty_d[c] = 4'h0;
            end
        end

        if (wr_en_i) begin
            for (int g = 0; g < NumGen; g++) begin
                if (wr_is_gen && (wr_addr_i == 8'(g))) begin
                    gen_d[g] = wr_data_i;
                end
            end
            for (int c = 0; c < NumCh; c++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((wr_is_ch && (wr_off[8:2] == 7'(c)) && (wr_off[1:0] == 2'(b))) ||
                        (wr_is_all && (wr_all_off[1:0] == 2'(b)))) begin
                        stage_d[c][b] = wr_data_i;
                        dirty_d[c][b] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_next = 8'h00;
        for (int g = 0; g < NumGen; g++) begin
            if (rd_is_gen && (rd_addr_i == 8'(g))) begin
                rd_next = gen_q[g];
            end
        end
        for (int c = 0; c < NumCh; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (rd_is_ch && (rd_off[8:2] == 7'(c)) && (rd_off[1:0] == 2'(b))) begin
                    rd_next = stage_q[c][b];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int g = 0; g < NumGen; g++) begin
                gen_q[g] <= 8'h00;
            end
            gen_q[Mode1Idx] <= MODE1_RST;
            gen_q[Mode2Idx] <= MODE2_RST;
            for (int c = 0; c < NumCh; c++) begin
                stage_q[c][ByteOnL]  <= LoByteRst;
                stage_q[c][ByteOnH]  <= OnHRst;
                stage_q[c][ByteOffL] <= LoByteRst;
                stage_q[c][ByteOffH] <= OffHRst;
                dirty_q[c]           <= 4'h0;
                on_q[c]              <= OnFieldRst;
                off_q[c]             <= OffFieldRst;
            end
            commit_q  <= '0;
            rd_data_q <= 8'h00;
        end else begin
            gen_q     <= gen_d;
            stage_q   <= stage_d;
            dirty_q   <= dirty_d;
            on_q      <= on_d;
            off_q     <= off_d;
            commit_q  <= commit_now;
            rd_data_q <= rd_next;
        end
    end

    for (genvar c = 0; c < NumCh; c++) begin : g_pack
        assign led_on_o[FieldW*c +: FieldW]  = on_q[c];
        assign led_off_o[FieldW*c +: FieldW] = off_q[c];
    end

    assign rd_data_o = rd_data_q;
    assign mode1_o   = gen_q[Mode1Idx];
    assign mode2_o   = gen_q[Mode2Idx];
    assign commit_o  = commit_q;

endmodule

// File: tb/tb_led_shadow_regs.sv
// Self-checking bench for led_shadow_regs: directed scenarios plus randomized traffic
// against a byte-level reference model of the register file.
module tb_led_shadow_regs;

    localparam int NC = 16;

    logic           clk = 1'b0;
    logic           rst, wr_en, i2c_stop;
    logic [7:0]     wr_addr, wr_data, rd_addr;
    logic [7:0]     rd_data, mode1, mode2;
    logic [13*NC-1:0] led_on, led_off;
    logic [NC-1:0]  commit;
    logic           scan_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_shadow_regs #(
        .NUM_CHANNELS (NC),
        .BASE_ADDR    (8'h06),
        .ALL_ADDR     (8'hFA),
        .MODE1_RST    (8'h11),
        .MODE2_RST    (8'h04)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .i2c_stop_i  (i2c_stop),
        .mode1_o     (mode1),
        .mode2_o     (mode2),
        .led_on_o    (led_on),
        .led_off_o   (led_off),
        .commit_o    (commit),
        .scan_busy_o (scan_busy)
    );

    // Reference model: plain byte arrays; the STOP scan is modelled by remembering the
    // cycle number of the STOP, so channel k is visited k+1 cycles later.
    logic [7:0]  m_gen   [6];
    logic [7:0]  m_stage [NC][4];
    logic        m_dirty [NC][4];
    logic [12:0] m_on    [NC];
    logic [12:0] m_off   [NC];
    logic [NC-1:0] m_com;
    logic [7:0]  m_rd;
    int          m_cyc = 0;
    int          m_scan_s = -100000;

    function automatic logic [12:0] m_field(input logic [7:0] hi, input logic [7:0] lo);
        return 13'((hi[4] ? 4096 : 0) + int'(hi & 8'h0F) * 256 + int'(lo));
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int ai = int'(a);
        if (ai < 6) return m_gen[ai];
        if (ai < 6 + 4 * NC) return m_stage[(ai - 6) / 4][(ai - 6) % 4];
        return 8'h00;
    endfunction

    function automatic int m_chan(input int cyc);
        int k = cyc - m_scan_s - 1;
        return (k >= 0 && k < NC) ? k : -1;
    endfunction

    function automatic logic [13*NC-1:0] m_on_vec();
        logic [13*NC-1:0] v;
        for (int c = 0; c < NC; c++) v[13*c +: 13] = m_on[c];
        return v;
    endfunction

    function automatic logic [13*NC-1:0] m_off_vec();
        logic [13*NC-1:0] v;
        for (int c = 0; c < NC; c++) v[13*c +: 13] = m_off[c];
        return v;
    endfunction

    task automatic m_reset();
        for (int g = 0; g < 6; g++) m_gen[g] = 8'h00;
        m_gen[0] = 8'h11;
        m_gen[1] = 8'h04;
        for (int c = 0; c < NC; c++) begin
            m_stage[c][0] = 8'h00; m_stage[c][1] = 8'h00;
            m_stage[c][2] = 8'h00; m_stage[c][3] = 8'h10;
            for (int b = 0; b < 4; b++) m_dirty[c][b] = 1'b0;
            m_on[c]  = 13'h0000;
            m_off[c] = 13'h1000;
        end
        m_com    = '0;
        m_rd     = 8'h00;
        m_scan_s = -100000;
    endtask

    // Advance model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        int k, a;
        logic och, all4, any4;
        logic [NC-1:0] com;
        logic [7:0] rdn;
        k = m_chan(m_cyc);
        if (rst) begin
            m_reset();
        end else begin
            och = m_gen[1][3];
            rdn = m_read(rd_addr);
            for (int c = 0; c < NC; c++) begin
                all4 = m_dirty[c][0] && m_dirty[c][1] && m_dirty[c][2] && m_dirty[c][3];
                any4 = m_dirty[c][0] || m_dirty[c][1] || m_dirty[c][2] || m_dirty[c][3];
                com[c] = (och && !wr_en && all4) || (k == c && any4);
            end
            for (int c = 0; c < NC; c++) begin
                if (com[c]) begin
                    m_on[c]  = m_field(m_stage[c][1], m_stage[c][0]);
                    m_off[c] = m_field(m_stage[c][3], m_stage[c][2]);
                    for (int b = 0; b < 4; b++) m_dirty[c][b] = 1'b0;
                end
            end
            if (wr_en) begin
                a = int'(wr_addr);
                if (a < 6) begin
                    m_gen[a] = wr_data;
                end else if (a < 6 + 4 * NC) begin
                    m_stage[(a - 6) / 4][(a - 6) % 4] = wr_data;
                    m_dirty[(a - 6) / 4][(a - 6) % 4] = 1'b1;
                end else if (a >= 250 && a <= 253) begin
                    for (int c = 0; c < NC; c++) begin
                        m_stage[c][a - 250] = wr_data;
                        m_dirty[c][a - 250] = 1'b1;
                    end
                end
            end
            if (i2c_stop && !och) m_scan_s = m_cyc;
            m_rd  = rdn;
            m_com = com;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic stop_pulse();
        i2c_stop = 1'b1;
        tick();
        i2c_stop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < NC; c++) begin
            n_tests++;
            if (led_off[13*c +: 13] !== 13'h1000) begin
                n_fail++;
                $display("FAIL reset_led_off ch%0d: got %h want 1000", c, led_off[13*c +: 13]);
            end
        end
        n_tests++;
        if (led_on !== '0) begin
            n_fail++; $display("FAIL reset_led_on: got %h want 0", led_on);
        end
        n_tests++;
        if (mode1 !== 8'h11) begin n_fail++; $display("FAIL reset_mode1: got %h want 11", mode1); end
        n_tests++;
        if (mode2 !== 8'h04) begin n_fail++; $display("FAIL reset_mode2: got %h want 04", mode2); end
        n_tests++;
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got %h want 00", rd_data); end
        n_tests++;
        if (scan_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", scan_busy); end
        n_tests++;
        if (commit !== '0) begin n_fail++; $display("FAIL reset_commit: got %h want 0", commit); end
    endtask

    task automatic test_och1();
        wr(8'h01, 8'h0C);
        n_tests++;
        if (mode2 !== 8'h0C) begin n_fail++; $display("FAIL och1_mode2: got %h want 0c", mode2); end
        wr(8'h12, 8'h34); wr(8'h13, 8'h12); wr(8'h14, 8'h78); wr(8'h15, 8'h05);
        n_tests++;
        if (commit !== '0 || led_on[39 +: 13] !== 13'h0000) begin
            n_fail++; $display("FAIL och1_early: got commit %h on %h want 0 0", commit, led_on[39 +: 13]);
        end
        tick();
        // ON_H 0x12 has bit4 set, so full_on is part of the packed value.
        n_tests++;
        if (led_on[39 +: 13] !== 13'h1234) begin
            n_fail++; $display("FAIL och1_on: got %h want 1234", led_on[39 +: 13]);
        end
        n_tests++;
        if (led_off[39 +: 13] !== 13'h0578) begin
            n_fail++; $display("FAIL och1_off: got %h want 0578", led_off[39 +: 13]);
        end
        n_tests++;
        if (commit !== 16'h0008) begin n_fail++; $display("FAIL och1_commit: got %h want 0008", commit); end
        tick();
        n_tests++;
        if (commit !== '0) begin n_fail++; $display("FAIL och1_once: got %h want 0000", commit); end
        wr(8'h16, 8'hAA); wr(8'h17, 8'h01); wr(8'h18, 8'h22);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (commit !== '0) begin n_fail++; $display("FAIL och1_partial: got %h want 0000", commit); end
        end
    endtask

    task automatic test_och0();
        logic [7:0] b0 [4];
        logic [7:0] b15 [4];
        int busy_cnt;
        logic [NC-1:0] exp_c;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            b0[b]  = 8'($urandom);
            b15[b] = 8'($urandom);
        end
        for (int b = 0; b < 4; b++) wr(8'(6 + b), b0[b]);
        for (int b = 0; b < 4; b++) wr(8'(6 + 60 + b), b15[b]);
        stop_pulse();
        busy_cnt = scan_busy ? 1 : 0;
        for (int j = 1; j <= 20; j++) begin
            tick();
            exp_c = (j == 1) ? 16'h0001 : (j == 16) ? 16'h8000 : 16'h0000;
            n_tests++;
            if (commit !== exp_c) begin
                n_fail++; $display("FAIL och0_commit +%0d: got %h want %h", j, commit, exp_c);
            end
            busy_cnt += scan_busy ? 1 : 0;
        end
        n_tests++;
        if (busy_cnt != 16) begin n_fail++; $display("FAIL och0_busy_len: got %0d want 16", busy_cnt); end
        n_tests++;
        if (led_on[0 +: 13] !== m_field(b0[1], b0[0]) || led_off[0 +: 13] !== m_field(b0[3], b0[2])) begin
            n_fail++; $display("FAIL och0_ch0: got %h/%h want %h/%h", led_on[0 +: 13],
                               led_off[0 +: 13], m_field(b0[1], b0[0]), m_field(b0[3], b0[2]));
        end
        n_tests++;
        if (led_on[195 +: 13] !== m_field(b15[1], b15[0])) begin
            n_fail++; $display("FAIL och0_ch15: got %h want %h", led_on[195 +: 13], m_field(b15[1], b15[0]));
        end
    endtask

    task automatic test_all_led();
        do_reset();
        wr(8'h01, 8'h0C);
        wr(8'hFA, 8'h00); wr(8'hFB, 8'h10); wr(8'hFC, 8'h00); wr(8'hFD, 8'h00);
        tick();
        n_tests++;
        if (commit !== 16'hFFFF) begin n_fail++; $display("FAIL all_commit: got %h want ffff", commit); end
        for (int c = 0; c < NC; c++) begin
            n_tests++;
            if (led_on[13*c +: 13] !== 13'h1000 || led_off[13*c +: 13] !== 13'h0000) begin
                n_fail++; $display("FAIL all_value ch%0d: got %h/%h want 1000/0000", c,
                                   led_on[13*c +: 13], led_off[13*c +: 13]);
            end
        end
        rd_addr = 8'hFA; tick();
        n_tests++;
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL all_rd_fa: got %h want 00", rd_data); end
        rd_addr = 8'h0A; tick();
        n_tests++;
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL all_rd_0a: got %h want 00", rd_data); end
        rd_addr = 8'h07; tick();
        n_tests++;
        if (rd_data !== 8'h10) begin n_fail++; $display("FAIL all_rd_07: got %h want 10", rd_data); end
        rd_addr = 8'h00; tick();
        n_tests++;
        if (rd_data !== 8'h11) begin n_fail++; $display("FAIL rd_mode1: got %h want 11", rd_data); end
    endtask

    task automatic test_collision();
        do_reset();
        wr(8'h1A, 8'hA1); wr(8'h1B, 8'hB2); wr(8'h1C, 8'hC3); wr(8'h1D, 8'hD4);
        stop_pulse();
        repeat (5) tick();
        wr(8'h1A, 8'h5A);
        n_tests++;
        if (commit !== 16'h0020 || led_on[65 +: 13] !== 13'h12A1) begin
            n_fail++; $display("FAIL coll_first: got %h/%h want 0020/12a1", commit, led_on[65 +: 13]);
        end
        n_tests++;
        if (led_off[65 +: 13] !== 13'h14C3) begin
            n_fail++; $display("FAIL coll_off: got %h want 14c3", led_off[65 +: 13]);
        end
        repeat (12) tick();
        n_tests++;
        if (led_on[65 +: 13] !== 13'h12A1 || scan_busy !== 1'b0) begin
            n_fail++; $display("FAIL coll_hold: got %h busy %b want 12a1 0", led_on[65 +: 13], scan_busy);
        end
        rd_addr = 8'h1A; tick();
        n_tests++;
        if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL coll_rd: got %h want 5a", rd_data); end
        stop_pulse();
        repeat (6) tick();
        n_tests++;
        if (commit !== 16'h0020 || led_on[65 +: 13] !== 13'h125A) begin
            n_fail++; $display("FAIL coll_second: got %h/%h want 0020/125a", commit, led_on[65 +: 13]);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [NC-1:0] acc;
        do_reset();
        for (int c = 0; c < NC; c++) wr(8'(6 + 4 * c), 8'(c + 1));
        stop_pulse();
        repeat (7) tick();
        n_tests++;
        if (commit !== 16'h0040) begin n_fail++; $display("FAIL mid_pre: got %h want 0040", commit); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (commit !== '0 || scan_busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_abort: got %h busy %b want 0000 0", commit, scan_busy);
        end
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            tick();
            acc |= commit;
        end
        n_tests++;
        if (acc !== '0 || led_on[91 +: 13] !== 13'h0000) begin
            n_fail++; $display("FAIL mid_quiet: got %h ch7 %h want 0000 0000", acc, led_on[91 +: 13]);
        end
    endtask

    task automatic test_random();
        int sel;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            sel      = $urandom_range(0, 9);
            wr_addr  = (sel == 0) ? 8'($urandom_range(0, 5)) :
                       (sel == 1) ? 8'($urandom_range(250, 253)) :
                       (sel == 2) ? 8'($urandom) : 8'($urandom_range(6, 69));
            wr_data  = 8'($urandom);
            i2c_stop = ($urandom_range(0, 19) == 0);
            rd_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 75));
            tick();
            n_tests++;
            if (rd_data !== m_rd) begin n_fail++; $display("FAIL rnd_rd @%0d: got %h want %h", i, rd_data, m_rd); end
            n_tests++;
            if (mode1 !== m_gen[0] || mode2 !== m_gen[1]) begin
                n_fail++; $display("FAIL rnd_mode @%0d: got %h/%h want %h/%h", i, mode1, mode2, m_gen[0], m_gen[1]);
            end
            n_tests++;
            if (led_on !== m_on_vec()) begin n_fail++; $display("FAIL rnd_on @%0d: got %h want %h", i, led_on, m_on_vec()); end
            n_tests++;
            if (led_off !== m_off_vec()) begin n_fail++; $display("FAIL rnd_off @%0d: got %h want %h", i, led_off, m_off_vec()); end
            n_tests++;
            if (commit !== m_com) begin n_fail++; $display("FAIL rnd_commit @%0d: got %h want %h", i, commit, m_com); end
            n_tests++;
            if (scan_busy !== (m_chan(m_cyc) >= 0)) begin
                n_fail++; $display("FAIL rnd_busy @%0d: got %b want %b", i, scan_busy, m_chan(m_cyc) >= 0);
            end
        end
        rst = 1'b0; wr_en = 1'b0; i2c_stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; i2c_stop = 1'b0;
        wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
        m_reset();
        test_reset();
        test_och1();
        test_och0();
        test_all_led();
        test_collision();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
